// File: rtl/pid_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pid_sequencer
// Description : Multi-cycle sequencer for the balance-loop PID datapath.
//               Saturates each accepted ptch_err sample, builds P, I and D
//               terms in successive states and emits a saturated 12-bit
//               drive command with a 1-cycle valid pulse.
//               Optional feature macro: PID_DROP_CNT_EN (dropped-sample count).
// Revision    : 1.0 - initial release
// ============================================================================
module pid_sequencer #(
    parameter int unsigned P_COEFF       = 12,
    parameter int unsigned D_COEFF       = 20,
    parameter int unsigned D_QUEUE_DEPTH = 2,
    parameter int unsigned I_SHIFT       = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vld,
    input  logic [15:0] ptch_err,
    input  logic        pwr_up,
    input  logic        clr_I,
    output logic [11:0] PID_cntrl,
    output logic        cntrl_vld,
    output logic        busy,
    output logic [7:0]  drop_cnt
);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_SAT  = 3'd1;
    localparam logic [2:0] c_ST_PT   = 3'd2;
    localparam logic [2:0] c_ST_IT   = 3'd3;
    localparam logic [2:0] c_ST_DT   = 3'd4;
    localparam logic [2:0] c_ST_SUM  = 3'd5;
    localparam logic [2:0] c_ST_DONE = 3'd6;

    localparam logic signed [15:0] c_P_GAIN = 16'(P_COEFF);
    localparam logic signed [12:0] c_D_GAIN = 13'(D_COEFF);

    logic [2:0]                    state_q, state_d;
    logic signed [15:0]            err_raw_q, err_raw_d;
    logic signed [9:0]             err_sat_q, err_sat_d;
    logic signed [15:0]            p_term_q, p_term_d;
    logic signed [17:0]            integ_q, integ_d;
    logic signed [11:0]            i_term_q, i_term_d;
    logic signed [12:0]            d_term_q, d_term_d;
    logic [11:0]                   pid_q, pid_d;
    logic                          cntrl_vld_q, cntrl_vld_d;
    logic [D_QUEUE_DEPTH-1:0][9:0] queue_q, queue_d;

    logic signed [9:0]  w_err_sat;
    logic signed [15:0] w_err_ext16;
    logic signed [15:0] w_p_prod;
    logic signed [17:0] w_err_ext18;
    logic signed [17:0] w_integ_sum;
    logic               w_integ_ovf;
    logic signed [17:0] w_integ_next;
    logic signed [9:0]  w_q_tap;
    logic signed [10:0] w_d_diff;
    logic signed [6:0]  w_d_sat;
    logic signed [12:0] w_d_ext13;
    logic signed [12:0] w_d_prod;
    logic signed [16:0] w_sum;
    logic [11:0]        w_sum_sat;

    // ------------------------------------------------------------------
    // Datapath: each term is computed from already-registered operands
    // ------------------------------------------------------------------
    always_comb begin
        w_err_sat = err_raw_q[9:0];
        if (err_raw_q > 16'sd511) begin
            w_err_sat = 10'sd511;
        end else if (err_raw_q < -16'sd512) begin
            w_err_sat = -10'sd512;
        end
    end

    assign w_err_ext16 = {{6{err_sat_q[9]}}, err_sat_q};
    assign w_p_prod    = w_err_ext16 * c_P_GAIN;

    assign w_err_ext18 = {{8{err_sat_q[9]}}, err_sat_q};
    assign w_integ_sum = integ_q + w_err_ext18;
    // Two's-complement overflow: same-sign operands yielding a different sign
    assign w_integ_ovf = (integ_q[17] == w_err_ext18[17]) && (w_integ_sum[17] != integ_q[17]);

    always_comb begin
        if (!pwr_up || clr_I) begin
            w_integ_next = '0;
        end else if (w_integ_ovf) begin
            w_integ_next = integ_q;
        end else begin
            w_integ_next = w_integ_sum;
        end
    end

    assign w_q_tap  = queue_q[D_QUEUE_DEPTH-1];
    assign w_d_diff = {err_sat_q[9], err_sat_q} - {w_q_tap[9], w_q_tap};

    always_comb begin
        w_d_sat = w_d_diff[6:0];
        if (w_d_diff > 11'sd63) begin
            w_d_sat = 7'sd63;
        end else if (w_d_diff < -11'sd64) begin
            w_d_sat = -7'sd64;
        end
    end

    assign w_d_ext13 = {{6{w_d_sat[6]}}, w_d_sat};
    assign w_d_prod  = w_d_ext13 * c_D_GAIN;

    assign w_sum = {p_term_q[15], p_term_q}
                 + {{5{i_term_q[11]}}, i_term_q}
                 + {{4{d_term_q[12]}}, d_term_q};

    always_comb begin
        w_sum_sat = w_sum[11:0];
        if (w_sum > 17'sd2047) begin
            w_sum_sat = 12'h7FF;
        end else if (w_sum < -17'sd2048) begin
            w_sum_sat = 12'h800;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer: one state per datapath stage, state updates gated here
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        err_raw_d   = err_raw_q;
        err_sat_d   = err_sat_q;
        p_term_d    = p_term_q;
        integ_d     = integ_q;
        i_term_d    = i_term_q;
        d_term_d    = d_term_q;
        pid_d       = pid_q;
        queue_d     = queue_q;
        cntrl_vld_d = (state_q == c_ST_SUM);

        case (state_q)
            c_ST_IDLE: begin
                if (vld) begin
                    state_d   = c_ST_SAT;
                    err_raw_d = ptch_err;
                end
            end
            c_ST_SAT: begin
                state_d   = c_ST_PT;
                err_sat_d = w_err_sat;
            end
            c_ST_PT: begin
                state_d  = c_ST_IT;
                p_term_d = w_p_prod;
            end
            c_ST_IT: begin
                state_d  = c_ST_DT;
                integ_d  = w_integ_next;
                i_term_d = 12'(w_integ_next >>> I_SHIFT);
            end
            c_ST_DT: begin
                state_d  = c_ST_SUM;
                d_term_d = w_d_prod;
            end
            c_ST_SUM: begin
                state_d    = c_ST_DONE;
                pid_d      = w_sum_sat;
                queue_d[0] = err_sat_q;
                for (int k = 1; k < int'(D_QUEUE_DEPTH); k++) begin
                    queue_d[k] = queue_q[k-1];
                end
            end
            c_ST_DONE: begin
                state_d = c_ST_IDLE;
            end
            default: begin
                state_d = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= c_ST_IDLE;
            err_raw_q   <= '0;
            err_sat_q   <= '0;
            p_term_q    <= '0;
            integ_q     <= '0;
            i_term_q    <= '0;
            d_term_q    <= '0;
            pid_q       <= '0;
            cntrl_vld_q <= 1'b0;
            queue_q     <= '0;
        end else begin
            state_q     <= state_d;
            err_raw_q   <= err_raw_d;
            err_sat_q   <= err_sat_d;
            p_term_q    <= p_term_d;
            integ_q     <= integ_d;
            i_term_q    <= i_term_d;
            d_term_q    <= d_term_d;
            pid_q       <= pid_d;
            cntrl_vld_q <= cntrl_vld_d;
            queue_q     <= queue_d;
        end
    end

    assign PID_cntrl = pid_q;
    assign cntrl_vld = cntrl_vld_q;
    assign busy      = (state_q != c_ST_IDLE) && (state_q != c_ST_DONE);

`ifdef PID_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    // Any strobe seen outside IDLE is a lost sample; count saturates
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (vld && (state_q != c_ST_IDLE) && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pid_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pid_sequencer
// Description : Directed self-checking bench for pid_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pid_sequencer;

`ifdef PID_DROP_CNT_EN
    localparam bit c_DROP_EN = 1'b1;
`else
    localparam bit c_DROP_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        vld;
    logic [15:0] ptch_err;
    logic        pwr_up;
    logic        clr_I;
    logic [11:0] PID_cntrl;
    logic        cntrl_vld;
    logic        busy;
    logic [7:0]  drop_cnt;

    int n_checks;
    int n_fail;

    pid_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vld       (vld),
        .ptch_err  (ptch_err),
        .pwr_up    (pwr_up),
        .clr_I     (clr_I),
        .PID_cntrl (PID_cntrl),
        .cntrl_vld (cntrl_vld),
        .busy      (busy),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Returns at the negedge inside DONE; lat counts cycles after the vld cycle
    task automatic run_sample(input logic [15:0] err, output int lat);
        @(negedge clk);
        vld      = 1'b1;
        ptch_err = err;
        @(negedge clk);
        vld = 1'b0;
        lat = 1;
        while (!cntrl_vld && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic count_pulses(input int n_cyc, output int cnt);
        cnt = 0;
        repeat (n_cyc) begin
            @(negedge clk);
            if (cntrl_vld) cnt++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int cnt;
        logic [15:0] t1_err [3];
        logic [11:0] t1_exp [3];
        logic [11:0] t4_exp [6];

        t1_err = '{16'h0004, 16'h0004, 16'h0004};
        t1_exp = '{12'd128, 12'd128, 12'd48};
        // P=768 each; D saturated (1260) for two samples then 0; I tracks integ>>>6
        t4_exp = '{12'd2029, 12'd2030, 12'd771, 12'd772, 12'd768, 12'd769};

        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        vld      = 1'b0;
        ptch_err = '0;
        pwr_up   = 1'b0;
        clr_I    = 1'b0;

        do_reset();
        check_eq("rst_pid",  32'(PID_cntrl), 32'd0);
        check_eq("rst_vld",  32'(cntrl_vld), 32'd0);
        check_eq("rst_busy", 32'(busy),      32'd0);
        check_eq("rst_drop", 32'(drop_cnt),  32'd0);

        for (int i = 0; i < 3; i++) begin
            run_sample(t1_err[i], lat);
            check_eq($sformatf("t1_lat%0d", i), 32'(lat), 32'd6);
            check_eq($sformatf("t1_pid%0d", i), 32'(PID_cntrl), 32'(t1_exp[i]));
        end

        do_reset();
        run_sample(16'h0100, lat);
        check_eq("t2_pos_sat", 32'(PID_cntrl), 32'h7FF);

        do_reset();
        run_sample(16'h8001, lat);
        check_eq("t3_neg_sat", 32'(PID_cntrl), 32'h800);

        do_reset();
        run_sample(16'hFFEC, lat);
        check_eq("neg_small", 32'(PID_cntrl), 32'hD80);

        do_reset();
        pwr_up = 1'b1;
        for (int i = 0; i < 6; i++) begin
            clr_I = (i == 4);
            run_sample(16'h0040, lat);
            check_eq($sformatf("t4_pid%0d", i), 32'(PID_cntrl), 32'(t4_exp[i]));
        end
        clr_I  = 1'b0;
        pwr_up = 1'b0;

        do_reset();
        @(negedge clk);
        vld      = 1'b1;
        ptch_err = 16'h0004;
        @(negedge clk);
        vld = 1'b0;
        check_eq("t5_busy", 32'(busy), 32'd1);
        @(negedge clk);
        vld = 1'b1;
        @(negedge clk);
        vld = 1'b0;
        count_pulses(12, cnt);
        check_eq("t5_pulses", 32'(cnt), 32'd1);
        check_eq("t5_drop", 32'(drop_cnt), c_DROP_EN ? 32'd1 : 32'd0);
        check_eq("t5_pid", 32'(PID_cntrl), 32'd128);

        run_sample(16'h0004, lat);
        vld = 1'b1;
        @(negedge clk);
        vld = 1'b0;
        count_pulses(10, cnt);
        check_eq("done_drop_pulses", 32'(cnt), 32'd0);
        check_eq("done_drop_cnt", 32'(drop_cnt), c_DROP_EN ? 32'd2 : 32'd0);
        check_eq("idle_busy", 32'(busy), 32'd0);

        do_reset();
        run_sample(16'h0004, lat);
        check_eq("t6_first", 32'(PID_cntrl), 32'd128);
        @(negedge clk);
        vld      = 1'b1;
        ptch_err = 16'h0004;
        @(negedge clk);
        vld = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("t6_busy_dt", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("t6_rst_busy", 32'(busy), 32'd0);
        check_eq("t6_rst_pid", 32'(PID_cntrl), 32'd0);
        rst_n = 1'b1;
        count_pulses(8, cnt);
        check_eq("t6_no_pulse", 32'(cnt), 32'd0);
        run_sample(16'h0004, lat);
        check_eq("t6_lat", 32'(lat), 32'd6);
        check_eq("t6_after", 32'(PID_cntrl), 32'd128);

        // Continuous strobe: one accept per 7 cycles, the rest are drops
        @(negedge clk);
        vld      = 1'b1;
        ptch_err = 16'h0000;
        repeat (400) @(negedge clk);
        vld = 1'b0;
        repeat (8) @(negedge clk);
        check_eq("drop_sat", 32'(drop_cnt), c_DROP_EN ? 32'hFF : 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
